// File: rtl/catch_referee_if.sv
// Signal bundle between the ball state machine, the referee and the score/display logic.
// The master side drives the ball-machine inputs; the slave side is the referee.
interface catch_referee_if;
  localparam int unsigned POS_W   = 16;
  localparam int unsigned COUNT_W = 8;
  localparam int unsigned DROPS_W = 4;

  logic               game_start;
  logic [1:0]         ball_state;
  logic [POS_W-1:0]   ball_x;
  logic [POS_W-1:0]   ball_y;
  logic               catch_event;
  logic               throw_event;

  logic [2:0]         ref_state;
  logic [COUNT_W-1:0] score;
  logic [COUNT_W-1:0] streak;
  logic [COUNT_W-1:0] best_streak;
  logic [DROPS_W-1:0] drops;
  logic [1:0]         last_thrower;
  logic               pass_event;
  logic               drop_event;
  logic               game_over;

  modport master (
    output game_start, ball_state, ball_x, ball_y, catch_event, throw_event,
    input  ref_state, score, streak, best_streak, drops, last_thrower,
           pass_event, drop_event, game_over
  );

  modport slave (
    input  game_start, ball_state, ball_x, ball_y, catch_event, throw_event,
    output ref_state, score, streak, best_streak, drops, last_thrower,
           pass_event, drop_event, game_over
  );
endinterface

// File: rtl/catch_referee.sv
// Game referee: scores passes between two gloves, detects drops and hold fouls,
// tracks streaks and ends the game after MAX_DROPS drops.
module catch_referee #(
  parameter int unsigned TICK_CYCLES      = 210938,
  parameter int unsigned FLOOR_MM         = 60,
  parameter int unsigned STALL_TICKS      = 16,
  parameter int unsigned MAX_FLIGHT_TICKS = 512,
  parameter int unsigned MAX_HOLD_TICKS   = 640,
  parameter int unsigned MAX_DROPS        = 3
) (
  input  logic            clk,
  input  logic            reset,
  catch_referee_if.slave  bus
);
  localparam int unsigned TICK_W   = $clog2(TICK_CYCLES + 1);
  localparam int unsigned HOLD_W   = $clog2(MAX_HOLD_TICKS + 1);
  localparam int unsigned FLIGHT_W = $clog2(MAX_FLIGHT_TICKS + 1);
  localparam int unsigned STALL_W  = $clog2(STALL_TICKS + 1);
  localparam int unsigned POS_W    = 16;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned DROPS_W  = 4;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_HOLD = 3'd1,
    S_HELD      = 3'd2,
    S_FLIGHT    = 3'd3,
    S_OVER      = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [1:0]          prev_state_q, prev_state_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [FLIGHT_W-1:0] flight_cnt_q, flight_cnt_d;
  logic [STALL_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [POS_W-1:0]    pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [CNT_W-1:0]    score_q, score_d, streak_q, streak_d, best_q, best_d;
  logic [DROPS_W-1:0]  drops_q, drops_d;
  logic [1:0]          last_thrower_q, last_thrower_d;
  logic                pass_ev_q, pass_ev_d, drop_ev_q, drop_ev_d;
  logic                game_over_q, game_over_d;

  logic [1:0]          ball_eff;
  logic                tick, pass_hit, drop_hit;
  logic [FLIGHT_W-1:0] flight_nxt;
  logic [STALL_W-1:0]  stall_nxt;
  logic [CNT_W-1:0]    streak_nxt;

  always_comb begin
    state_d        = state_q;
    prev_state_d   = prev_state_q;
    hold_cnt_d     = hold_cnt_q;
    flight_cnt_d   = flight_cnt_q;
    stall_cnt_d    = stall_cnt_q;
    pos_x_d        = pos_x_q;
    pos_y_d        = pos_y_q;
    score_d        = score_q;
    streak_d       = streak_q;
    best_d         = best_q;
    drops_d        = drops_q;
    last_thrower_d = last_thrower_q;
    pass_ev_d      = 1'b0;
    drop_ev_d      = 1'b0;
    pass_hit       = 1'b0;
    drop_hit       = 1'b0;
    flight_nxt     = flight_cnt_q;
    stall_nxt      = stall_cnt_q;
    streak_nxt     = streak_q;

    // Invalid ball_state (3) behaves as "in air".
    ball_eff     = (bus.ball_state == 2'd3) ? 2'd0 : bus.ball_state;
    tick         = (tick_cnt_q == '0);
    tick_cnt_d   = tick ? TICK_W'(TICK_CYCLES - 1) : tick_cnt_q - TICK_W'(1);
    prev_state_d = ball_eff;

    case (state_q)
      S_IDLE, S_OVER: begin
        if (bus.game_start) begin
          score_d        = '0;
          streak_d       = '0;
          best_d         = '0;
          drops_d        = '0;
          last_thrower_d = '0;
          hold_cnt_d     = '0;
          flight_cnt_d   = '0;
          stall_cnt_d    = '0;
          state_d        = (ball_eff != 2'd0) ? S_HELD : S_WAIT_HOLD;
        end
      end
      S_WAIT_HOLD: begin
        if (ball_eff != 2'd0) begin
          state_d    = S_HELD;
          hold_cnt_d = '0;
        end
      end
      S_HELD: begin
        if (bus.throw_event) begin
          state_d        = S_FLIGHT;
          last_thrower_d = prev_state_q;
          flight_cnt_d   = '0;
          stall_cnt_d    = '0;
          pos_x_d        = bus.ball_x;
          pos_y_d        = bus.ball_y;
        end else if (tick) begin
          if (hold_cnt_q == HOLD_W'(MAX_HOLD_TICKS - 1)) begin
            hold_cnt_d = '0;
            drop_hit   = 1'b1;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end
      end
      S_FLIGHT: begin
        if (tick) begin
          flight_nxt = (flight_cnt_q == FLIGHT_W'(MAX_FLIGHT_TICKS)) ? flight_cnt_q
                                                                     : flight_cnt_q + FLIGHT_W'(1);
          if (bus.ball_x == pos_x_q && bus.ball_y == pos_y_q)
            stall_nxt = (stall_cnt_q == STALL_W'(STALL_TICKS)) ? stall_cnt_q
                                                               : stall_cnt_q + STALL_W'(1);
          else
            stall_nxt = '0;
          pos_x_d = bus.ball_x;
          pos_y_d = bus.ball_y;
        end
        flight_cnt_d = flight_nxt;
        stall_cnt_d  = stall_nxt;
        // A catch outranks every drop condition on the same cycle.
        if (bus.catch_event && ball_eff != 2'd0) begin
          state_d    = S_HELD;
          hold_cnt_d = '0;
          pass_hit   = (ball_eff != last_thrower_q);
        end else if (bus.ball_y < POS_W'(FLOOR_MM) ||
                     stall_nxt == STALL_W'(STALL_TICKS) ||
                     flight_nxt == FLIGHT_W'(MAX_FLIGHT_TICKS)) begin
          state_d  = S_WAIT_HOLD;
          drop_hit = 1'b1;
        end else if (ball_eff != 2'd0) begin
          state_d    = S_HELD;
          hold_cnt_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pass_hit) begin
      pass_ev_d  = 1'b1;
      score_d    = (score_q == '1) ? score_q : score_q + CNT_W'(1);
      streak_nxt = (streak_q == '1) ? streak_q : streak_q + CNT_W'(1);
      streak_d   = streak_nxt;
      best_d     = (streak_nxt > best_q) ? streak_nxt : best_q;
    end

    if (drop_hit) begin
      drop_ev_d = 1'b1;
      streak_d  = '0;
      drops_d   = (drops_q >= DROPS_W'(MAX_DROPS)) ? drops_q : drops_q + DROPS_W'(1);
      if (drops_d >= DROPS_W'(MAX_DROPS))
        state_d = S_OVER;
    end

    game_over_d = (state_d == S_OVER);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      tick_cnt_q     <= TICK_W'(TICK_CYCLES - 1);
      prev_state_q   <= '0;
      hold_cnt_q     <= '0;
      flight_cnt_q   <= '0;
      stall_cnt_q    <= '0;
      pos_x_q        <= '0;
      pos_y_q        <= '0;
      score_q        <= '0;
      streak_q       <= '0;
      best_q         <= '0;
      drops_q        <= '0;
      last_thrower_q <= '0;
      pass_ev_q      <= 1'b0;
      drop_ev_q      <= 1'b0;
      game_over_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      tick_cnt_q     <= tick_cnt_d;
      prev_state_q   <= prev_state_d;
      hold_cnt_q     <= hold_cnt_d;
      flight_cnt_q   <= flight_cnt_d;
      stall_cnt_q    <= stall_cnt_d;
      pos_x_q        <= pos_x_d;
      pos_y_q        <= pos_y_d;
      score_q        <= score_d;
      streak_q       <= streak_d;
      best_q         <= best_d;
      drops_q        <= drops_d;
      last_thrower_q <= last_thrower_d;
      pass_ev_q      <= pass_ev_d;
      drop_ev_q      <= drop_ev_d;
      game_over_q    <= game_over_d;
    end
  end

  assign bus.ref_state    = state_q;
  assign bus.score        = score_q;
  assign bus.streak       = streak_q;
  assign bus.best_streak  = best_q;
  assign bus.drops        = drops_q;
  assign bus.last_thrower = last_thrower_q;
  assign bus.pass_event   = pass_ev_q;
  assign bus.drop_event   = drop_ev_q;
  assign bus.game_over    = game_over_q;
endmodule
